op_writeback: RTL

//  Result-consuming end of the execute datapath. Accepts Rd/flag results from the op_* units (ADD/ADC, etc.),

---
 rtl/op_writeback.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/op_writeback.sv
// Execute-side writeback: buffers op_* results in a small FIFO and commits them in order
// to the register file and APSR, with a per-register busy scoreboard and r15 redirect.
module op_writeback #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        wb_we,
  input  logic        wb_S,
  input  logic        wb_n,
  input  logic        wb_z,
  input  logic        wb_c,
  input  logic        wb_v,
  input  logic        commit_en,
  input  logic        iss_valid,
  input  logic [3:0]  iss_rd,
  input  logic        iss_we,
  input  logic [3:0]  rn_idx,
  input  logic [3:0]  rm_idx,
  input  logic [31:0] pc_in,
  output logic [31:0] Rn,
  output logic [31:0] Rm,
  output logic        rn_busy,
  output logic        rm_busy,
  output logic        neg_q,
  output logic        zero_q,
  output logic        carry_q,
  output logic        ovf_q,
  output logic        flags_pending,
  output logic        pc_load,
  output logic [31:0] pc_value
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        s;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } ent_t;

  ent_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   rf_q [16];
  logic [15:0]   busy_q, busy_d;
  logic          neg_d, zero_d, carry_d, ovf_d;
  logic          pc_load_d;
  logic [31:0]   pc_value_d;

  logic          push, pop, rf_we;
  ent_t          head, wr_ent;
  logic [AW-1:0] scan_idx;

  assign wb_ready = (count_q < CW'(DEPTH));
  assign push     = wb_valid & wb_ready;
  assign pop      = (count_q != '0) & commit_en;
  assign head     = fifo_q[rd_ptr_q];
  assign rf_we    = pop & head.we & (head.rd != 4'd15);

  assign wr_ent = '{rd: wb_rd, data: wb_data, we: wb_we, s: wb_S,
                    n: wb_n, z: wb_z, c: wb_c, v: wb_v};

  // Combinational read ports; r15 reads return the live PC.
  always_comb begin
    Rn      = (rn_idx == 4'd15) ? pc_in : rf_q[rn_idx];
    Rm      = (rm_idx == 4'd15) ? pc_in : rf_q[rm_idx];
    rn_busy = busy_q[rn_idx];
    rm_busy = busy_q[rm_idx];
  end

  // Scan live FIFO entries for a pending flag update.
  always_comb begin
    flags_pending = 1'b0;
    scan_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && fifo_q[scan_idx].s)
        flags_pending = 1'b1;
    end
  end

  // Next-state: pointers, commit effects on flags/PC, scoreboard set/clear.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    busy_d     = busy_q;
    neg_d      = neg_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    pc_load_d  = 1'b0;
    pc_value_d = pc_value;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop) begin
      if (head.we) begin
        if (head.rd == 4'd15) begin
          pc_load_d  = 1'b1;
          pc_value_d = {head.data[31:1], 1'b0};
        end else begin
          busy_d[head.rd] = 1'b0;
        end
      end
      if (head.s) begin
        neg_d   = head.n;
        zero_d  = head.z;
        carry_d = head.c;
        ovf_d   = head.v;
      end
    end
    // A fresh issue to the same rd outranks a commit clear.
    if (iss_valid && iss_we && (iss_rd != 4'd15))
      busy_d[iss_rd] = 1'b1;
    busy_d[15] = 1'b0;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      pc_load  <= 1'b0;
      pc_value <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      pc_load  <= pc_load_d;
      pc_value <= pc_value_d;
    end
  end

  // Register file; slot 15 is never written since r15 reads come from pc_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        rf_q[i] <= (i == 13) ? SP_RESET : 32'h0;
    end else if (rf_we) begin
      rf_q[head.rd] <= head.data;
    end
  end

  // FIFO payload storage; validity is tracked by count/pointers only.
  always_ff @(posedge clk) begin
    if (push && !rst)
      fifo_q[wr_ptr_q] <= wr_ent;
  end

endmodule
